// File: rtl/seg7_scan_if.sv
// Display bus between the value source and the 7-segment scanner.
// Latency: none, wires only.
// Backpressure: none; the scanner samples data_in at frame boundaries.
interface seg7_scan_if;
  logic        en;
  logic [15:0] data_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  modport master (
    output en, data_in,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  en, data_in,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/seg7_scan.sv
// Scans a 16-bit word as 4 hex digits onto a multiplexed 7-segment panel.
// Latency: an/seg/dp lag the digit index by 1 cycle; new data shows one frame after the wrap capture.
// Backpressure: none; data_in is sampled only on the 3->0 digit wrap, or every cycle while disabled.
module seg7_scan #(
  parameter int         CLK_DIV        = 50000,
  parameter bit         SEG_ACTIVE_LOW = 1'b1,
  parameter bit         AN_ACTIVE_LOW  = 1'b1,
  parameter bit         BLANK_LZ       = 1'b1,
  parameter logic [3:0] DP_MASK        = 4'b0000
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_scan_if.slave    io_disp
);

  localparam int              CW       = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0]   CNT_MAX  = CW'(CLK_DIV - 1);
  // Pin levels for a dark digit, segment or decimal point.
  localparam logic [6:0]      SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic            DP_OFF   = SEG_ACTIVE_LOW ? 1'b1  : 1'b0;
  localparam logic [3:0]      AN_OFF   = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_dig;
  logic [15:0]   r_shd;
  logic          r_frame_tick;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic [3:0]    w_nib;
  logic          w_blank;
  logic [6:0]    w_hex;
  logic [6:0]    w_seg;
  logic [3:0]    w_an;
  logic          w_dp;

  // Decode the current digit of the shadow word into pin levels.
  always_comb begin
    w_nib   = 4'h0;
    w_blank = 1'b0;
    w_hex   = 7'h00;
    case (r_dig)
      2'd0: begin w_nib = r_shd[3:0];   w_blank = 1'b0;                  end
      2'd1: begin w_nib = r_shd[7:4];   w_blank = (r_shd[15:4]  == '0);  end
      2'd2: begin w_nib = r_shd[11:8];  w_blank = (r_shd[15:8]  == '0);  end
      default: begin w_nib = r_shd[15:12]; w_blank = (r_shd[15:12] == '0); end
    endcase
    case (w_nib)
      4'h0: w_hex = 7'h3F;  4'h1: w_hex = 7'h06;
      4'h2: w_hex = 7'h5B;  4'h3: w_hex = 7'h4F;
      4'h4: w_hex = 7'h66;  4'h5: w_hex = 7'h6D;
      4'h6: w_hex = 7'h7D;  4'h7: w_hex = 7'h07;
      4'h8: w_hex = 7'h7F;  4'h9: w_hex = 7'h6F;
      4'hA: w_hex = 7'h77;  4'hB: w_hex = 7'h7C;
      4'hC: w_hex = 7'h39;  4'hD: w_hex = 7'h5E;
      4'hE: w_hex = 7'h79;  default: w_hex = 7'h71;
    endcase
    // A blanked digit keeps its anode and decimal point, only segments go dark.
    if (BLANK_LZ && w_blank) w_hex = 7'h00;
    w_seg = SEG_ACTIVE_LOW ? ~w_hex : w_hex;
    w_an  = 4'b0001 << r_dig;
    if (AN_ACTIVE_LOW) w_an = ~w_an;
    w_dp  = SEG_ACTIVE_LOW ? ~DP_MASK[r_dig] : DP_MASK[r_dig];
  end

  // Prescaler, digit index and frame-boundary capture of data_in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_dig        <= 2'd0;
      r_shd        <= 16'h0000;
      r_frame_tick <= 1'b0;
    end else if (!io_disp.en) begin
      // Tracking data_in while idle lets the first slot after enable show fresh data.
      r_cnt        <= '0;
      r_dig        <= 2'd0;
      r_shd        <= io_disp.data_in;
      r_frame_tick <= 1'b0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      r_dig <= r_dig + 2'd1;
      if (r_dig == 2'd3) begin
        r_shd        <= io_disp.data_in;
        r_frame_tick <= 1'b1;
      end else begin
        r_frame_tick <= 1'b0;
      end
    end else begin
      r_cnt        <= r_cnt + CW'(1);
      r_frame_tick <= 1'b0;
    end
  end

  // Registered pin drivers so the panel never sees decode glitches.
  always_ff @(posedge clk) begin
    if (!rst_n || !io_disp.en) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign io_disp.seg        = r_seg;
  assign io_disp.dp         = r_dp;
  assign io_disp.an         = r_an;
  assign io_disp.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with CLK_DIV=4 and default polarity/blanking.
// Each task drives a scenario and checks every cycle against hand-computed tables.
// Frames are 16 cycles; slot k of a frame occupies cycles 4k..4k+3.
module tb_seg7_scan;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  seg7_scan_if disp();

  seg7_scan #(.CLK_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_disp (disp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    disp.en = 1'b0;
    disp.data_in = 16'h0000;
    for (int i = 0; i < 3; i++) tick();
    n_tests++; if (disp.an !== 4'hF) begin n_fail++; $display("FAIL reset_an got=%h exp=%h", disp.an, 4'hF); end
    n_tests++; if (disp.seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got=%h exp=%h", disp.seg, 7'h7F); end
    n_tests++; if (disp.dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got=%b exp=1", disp.dp); end
    n_tests++; if (disp.frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_ft got=%b exp=0", disp.frame_tick); end
  endtask

  task automatic test_zero_frame();
    logic [3:0] ea;
    logic [6:0] es;
    rst_n = 1'b1;
    disp.en = 1'b1;
    disp.data_in = 16'h0000;
    for (int c = 0; c < 16; c++) begin
      tick();
      ea = 4'b0001 << (c / 4);
      ea = ~ea;
      es = (c < 4) ? 7'h40 : 7'h7F;
      n_tests++; if (disp.an !== ea) begin n_fail++; $display("FAIL zero_an c=%0d got=%b exp=%b", c, disp.an, ea); end
      n_tests++; if (disp.seg !== es) begin n_fail++; $display("FAIL zero_seg c=%0d got=%h exp=%h", c, disp.seg, es); end
      n_tests++; if (disp.dp !== 1'b1) begin n_fail++; $display("FAIL zero_dp c=%0d got=%b exp=1", c, disp.dp); end
      n_tests++; if (disp.frame_tick !== (c == 15)) begin n_fail++; $display("FAIL zero_ft c=%0d got=%b exp=%b", c, disp.frame_tick, c == 15); end
    end
  endtask

  task automatic test_lz_blank();
    logic [6:0] tbl [0:1][0:3];
    logic [3:0] ea;
    tbl = '{'{7'h40, 7'h7F, 7'h7F, 7'h7F}, '{7'h12, 7'h08, 7'h7F, 7'h7F}};
    disp.data_in = 16'h00A5;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 16; c++) begin
        tick();
        ea = 4'b0001 << (c / 4);
        ea = ~ea;
        n_tests++; if (disp.an !== ea) begin n_fail++; $display("FAIL a5_an f=%0d c=%0d got=%b exp=%b", f, c, disp.an, ea); end
        n_tests++; if (disp.seg !== tbl[f][c/4]) begin n_fail++; $display("FAIL a5_seg f=%0d c=%0d got=%h exp=%h", f, c, disp.seg, tbl[f][c/4]); end
        n_tests++; if (disp.frame_tick !== (c == 15)) begin n_fail++; $display("FAIL a5_ft f=%0d c=%0d got=%b exp=%b", f, c, disp.frame_tick, c == 15); end
      end
    end
  endtask

  task automatic test_no_blank();
    logic [6:0] tbl [0:1][0:3];
    tbl = '{'{7'h12, 7'h08, 7'h7F, 7'h7F}, '{7'h40, 7'h40, 7'h40, 7'h79}};
    disp.data_in = 16'h1000;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 16; c++) begin
        tick();
        n_tests++; if (disp.seg !== tbl[f][c/4]) begin n_fail++; $display("FAIL nolz_seg f=%0d c=%0d got=%h exp=%h", f, c, disp.seg, tbl[f][c/4]); end
        n_tests++; if (disp.frame_tick !== (c == 15)) begin n_fail++; $display("FAIL nolz_ft f=%0d c=%0d got=%b exp=%b", f, c, disp.frame_tick, c == 15); end
      end
    end
  endtask

  task automatic test_mid_frame_change();
    logic [6:0] tbl [0:2][0:3];
    tbl = '{'{7'h40, 7'h40, 7'h40, 7'h79},
            '{7'h79, 7'h79, 7'h79, 7'h79},
            '{7'h24, 7'h24, 7'h24, 7'h24}};
    disp.data_in = 16'h1111;
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 16; c++) begin
        tick();
        n_tests++; if (disp.seg !== tbl[f][c/4]) begin n_fail++; $display("FAIL mid_seg f=%0d c=%0d got=%h exp=%h", f, c, disp.seg, tbl[f][c/4]); end
        n_tests++; if (disp.frame_tick !== (c == 15)) begin n_fail++; $display("FAIL mid_ft f=%0d c=%0d got=%b exp=%b", f, c, disp.frame_tick, c == 15); end
        // Internal digit index is 1 here; the change must stay hidden this frame.
        if (f == 1 && c == 4) disp.data_in = 16'h2222;
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [6:0] tbl [0:3];
    logic [3:0] ea;
    tbl = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    for (int c = 0; c < 9; c++) tick();
    n_tests++; if (disp.an !== 4'b1011) begin n_fail++; $display("FAIL rmid_pre_an got=%b exp=1011", disp.an); end
    rst_n = 1'b0;
    tick();
    n_tests++; if (disp.an !== 4'hF) begin n_fail++; $display("FAIL rmid_an got=%b exp=1111", disp.an); end
    n_tests++; if (disp.seg !== 7'h7F) begin n_fail++; $display("FAIL rmid_seg got=%h exp=7f", disp.seg); end
    n_tests++; if (disp.dp !== 1'b1) begin n_fail++; $display("FAIL rmid_dp got=%b exp=1", disp.dp); end
    n_tests++; if (disp.frame_tick !== 1'b0) begin n_fail++; $display("FAIL rmid_ft got=%b exp=0", disp.frame_tick); end
    rst_n = 1'b1;
    // Shadow was cleared, so the restarted frame shows a blanked zero, not 2222.
    for (int c = 0; c < 16; c++) begin
      tick();
      ea = 4'b0001 << (c / 4);
      ea = ~ea;
      n_tests++; if (disp.an !== ea) begin n_fail++; $display("FAIL rmid_scan_an c=%0d got=%b exp=%b", c, disp.an, ea); end
      n_tests++; if (disp.seg !== tbl[c/4]) begin n_fail++; $display("FAIL rmid_scan_seg c=%0d got=%h exp=%h", c, disp.seg, tbl[c/4]); end
      n_tests++; if (disp.frame_tick !== (c == 15)) begin n_fail++; $display("FAIL rmid_scan_ft c=%0d got=%b exp=%b", c, disp.frame_tick, c == 15); end
    end
  endtask

  task automatic test_enable_low();
    logic [6:0] tbl [0:3];
    logic [3:0] ea;
    tbl = '{7'h0E, 7'h06, 7'h06, 7'h03};
    disp.en = 1'b0;
    disp.data_in = 16'hBEEF;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++; if (disp.an !== 4'hF) begin n_fail++; $display("FAIL enlow_an c=%0d got=%b exp=1111", c, disp.an); end
      n_tests++; if (disp.seg !== 7'h7F) begin n_fail++; $display("FAIL enlow_seg c=%0d got=%h exp=7f", c, disp.seg); end
      n_tests++; if (disp.dp !== 1'b1) begin n_fail++; $display("FAIL enlow_dp c=%0d got=%b exp=1", c, disp.dp); end
      n_tests++; if (disp.frame_tick !== 1'b0) begin n_fail++; $display("FAIL enlow_ft c=%0d got=%b exp=0", c, disp.frame_tick); end
    end
    disp.en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick();
      ea = 4'b0001 << (c / 4);
      ea = ~ea;
      n_tests++; if (disp.an !== ea) begin n_fail++; $display("FAIL enhi_an c=%0d got=%b exp=%b", c, disp.an, ea); end
      n_tests++; if (disp.seg !== tbl[c/4]) begin n_fail++; $display("FAIL enhi_seg c=%0d got=%h exp=%h", c, disp.seg, tbl[c/4]); end
      n_tests++; if (disp.frame_tick !== (c == 15)) begin n_fail++; $display("FAIL enhi_ft c=%0d got=%b exp=%b", c, disp.frame_tick, c == 15); end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_zero_frame();
    test_lz_blank();
    test_no_blank();
    test_mid_frame_change();
    test_reset_mid_scan();
    test_enable_low();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
